// File: rtl/chmu_epoch_sched.sv
// Epoch scheduler and front-end arbiter for the CHMU hot-page tracker.
// Optional per-requester epoch statistics are built when CHMU_EPOCH_STATS_EN is defined.
module chmu_epoch_sched #(
  parameter int ADDR_SIZE     = 21,
  parameter int CNT_SIZE      = 12,
  parameter int EPOCH_W       = 32,
  parameter int BUF_DEPTH     = 32,
  parameter int QUERY_TIMEOUT = 4096
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cfg_enable,
  input  logic [EPOCH_W-1:0]                   cfg_epoch_len,
  input  logic                                 cfg_force,
  input  logic [ADDR_SIZE-1:0]                 rd_addr,
  input  logic                                 rd_valid,
  output logic                                 rd_ready,
  input  logic [ADDR_SIZE-1:0]                 wr_addr,
  input  logic                                 wr_valid,
  output logic                                 wr_ready,
  output logic [ADDR_SIZE-1:0]                 trk_addr,
  output logic                                 trk_addr_valid,
  input  logic                                 trk_addr_ready,
  output logic                                 trk_query_en,
  input  logic                                 trk_query_ready,
  input  logic                                 trk_mig_en,
  input  logic [ADDR_SIZE+CNT_SIZE-1:0]        trk_mig_data,
  output logic                                 trk_mig_ready,
  output logic [ADDR_SIZE+CNT_SIZE-1:0]        hot_data,
  output logic                                 hot_valid,
  input  logic                                 hot_pop,
  output logic [$clog2(BUF_DEPTH):0]           hot_count,
  output logic                                 epoch_done,
  output logic [15:0]                          epoch_id,
  output logic                                 err_timeout,
  output logic                                 err_overrun,
  output logic [31:0]                          stat_rd_cnt,
  output logic [31:0]                          stat_wr_cnt
);

  localparam int ENT_W  = ADDR_SIZE + CNT_SIZE;
  localparam int PTR_W  = $clog2(BUF_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int QCNT_W = $clog2(QUERY_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_QUERY = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [EPOCH_W-1:0]  r_timer;
  logic [QCNT_W-1:0]   r_qcnt;
  logic                r_rr_wr;
  logic [ENT_W-1:0]    r_mem [BUF_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic                r_epoch_done;
  logic [15:0]         r_epoch_id;
  logic                r_err_timeout;
  logic                r_err_overrun;

  logic w_run;
  logic w_sel_wr;
  logic w_xfer;
  logic w_epoch_hit;
  logic w_q_timeout;
  logic w_q_enter;
  logic w_q_leave;
  logic w_full;
  logic w_push;
  logic w_pop;

  // Arbiter: round-robin only matters when both requesters contend.
  assign w_run          = (r_state == ST_RUN);
  assign w_sel_wr       = (rd_valid && wr_valid) ? r_rr_wr : wr_valid;
  assign trk_addr_valid = w_run && (rd_valid || wr_valid);
  assign trk_addr       = w_run ? (w_sel_wr ? wr_addr : rd_addr) : '0;
  assign rd_ready       = w_run && rd_valid && !w_sel_wr && trk_addr_ready;
  assign wr_ready       = w_run && wr_valid && w_sel_wr && trk_addr_ready;
  assign w_xfer         = trk_addr_valid && trk_addr_ready;

  assign w_epoch_hit = (cfg_epoch_len != '0) &&
                       (r_timer == cfg_epoch_len - EPOCH_W'(1));
  assign w_q_timeout = (r_qcnt == QCNT_W'(QUERY_TIMEOUT - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_q_enter   = 1'b0;
    w_q_leave   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cfg_enable) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!cfg_enable) begin
          w_state_nxt = ST_IDLE;
        end else if (w_epoch_hit || cfg_force) begin
          w_state_nxt = ST_QUERY;
          w_q_enter   = 1'b1;
        end
      end
      ST_QUERY: begin
        if (trk_query_ready || w_q_timeout) begin
          w_q_leave   = 1'b1;
          w_state_nxt = cfg_enable ? ST_RUN : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_qcnt  <= '0;
      r_rr_wr <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= (w_run && w_state_nxt == ST_RUN) ? r_timer + EPOCH_W'(1) : '0;
      r_qcnt  <= (r_state == ST_QUERY && !w_q_leave) ? r_qcnt + QCNT_W'(1) : '0;
      if (w_xfer) r_rr_wr <= ~r_rr_wr;
    end
  end

  assign trk_query_en = (r_state == ST_QUERY);

  // Hot-list FIFO: filled only during QUERY, flushed on every QUERY entry.
  assign w_full        = (r_count == CNT_W'(BUF_DEPTH));
  assign trk_mig_ready = trk_query_en && !w_full;
  assign w_push        = trk_mig_en && trk_mig_ready;
  assign w_pop         = hot_pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (rst || w_q_enter) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= trk_mig_data;
  end

  assign hot_valid = (r_count != '0);
  assign hot_data  = hot_valid ? r_mem[r_rd_ptr] : '0;
  assign hot_count = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_epoch_done  <= 1'b0;
      r_epoch_id    <= '0;
      r_err_timeout <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      r_epoch_done <= w_q_leave;
      if (w_q_leave) r_epoch_id <= r_epoch_id + 16'd1;
      if (w_q_leave && !trk_query_ready) r_err_timeout <= 1'b1;
      if (w_q_enter && r_count != '0)    r_err_overrun <= 1'b1;
    end
  end

  assign epoch_done  = r_epoch_done;
  assign epoch_id    = r_epoch_id;
  assign err_timeout = r_err_timeout;
  assign err_overrun = r_err_overrun;

`ifdef CHMU_EPOCH_STATS_EN
  logic [31:0] r_rd_cnt;
  logic [31:0] r_wr_cnt;
  logic [31:0] r_stat_rd;
  logic [31:0] r_stat_wr;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
    return (v == 32'hFFFF_FFFF) ? v : v + {31'd0, inc};
  endfunction

  // Snapshot includes a transfer accepted in the QUERY entry cycle itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
      r_stat_rd <= '0;
      r_stat_wr <= '0;
    end else if (w_q_enter) begin
      r_stat_rd <= sat_inc(r_rd_cnt, rd_ready);
      r_stat_wr <= sat_inc(r_wr_cnt, wr_ready);
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
    end else begin
      r_rd_cnt <= sat_inc(r_rd_cnt, rd_ready);
      r_wr_cnt <= sat_inc(r_wr_cnt, wr_ready);
    end
  end

  assign stat_rd_cnt = r_stat_rd;
  assign stat_wr_cnt = r_stat_wr;
`else
  assign stat_rd_cnt = '0;
  assign stat_wr_cnt = '0;
`endif

endmodule

// File: tb/tb_chmu_epoch_sched.sv
// Bench for chmu_epoch_sched: directed scenarios plus randomized traffic,
// all checked each cycle against a queue-based behavioural model.
module tb_chmu_epoch_sched;
  localparam int ADDR_SIZE = 21;
  localparam int CNT_SIZE  = 12;
  localparam int EPOCH_W   = 32;
  localparam int BUF_DEPTH = 4;
  localparam int QT        = 16;
  localparam int ENT_W     = ADDR_SIZE + CNT_SIZE;
  localparam int HC_W      = $clog2(BUF_DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cfg_enable;
  logic [EPOCH_W-1:0]   cfg_epoch_len;
  logic                 cfg_force;
  logic [ADDR_SIZE-1:0] rd_addr, wr_addr, trk_addr;
  logic                 rd_valid, rd_ready, wr_valid, wr_ready;
  logic                 trk_addr_valid, trk_addr_ready;
  logic                 trk_query_en, trk_query_ready;
  logic                 trk_mig_en, trk_mig_ready;
  logic [ENT_W-1:0]     trk_mig_data, hot_data;
  logic                 hot_valid, hot_pop;
  logic [HC_W-1:0]      hot_count;
  logic                 epoch_done;
  logic [15:0]          epoch_id;
  logic                 err_timeout, err_overrun;
  logic [31:0]          stat_rd_cnt, stat_wr_cnt;

  chmu_epoch_sched #(
    .ADDR_SIZE(ADDR_SIZE), .CNT_SIZE(CNT_SIZE), .EPOCH_W(EPOCH_W),
    .BUF_DEPTH(BUF_DEPTH), .QUERY_TIMEOUT(QT)
  ) dut (
    .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_epoch_len(cfg_epoch_len),
    .cfg_force(cfg_force), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .wr_addr(wr_addr), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .trk_addr(trk_addr), .trk_addr_valid(trk_addr_valid), .trk_addr_ready(trk_addr_ready),
    .trk_query_en(trk_query_en), .trk_query_ready(trk_query_ready),
    .trk_mig_en(trk_mig_en), .trk_mig_data(trk_mig_data), .trk_mig_ready(trk_mig_ready),
    .hot_data(hot_data), .hot_valid(hot_valid), .hot_pop(hot_pop), .hot_count(hot_count),
    .epoch_done(epoch_done), .epoch_id(epoch_id), .err_timeout(err_timeout),
    .err_overrun(err_overrun), .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 running, 2 querying.
  int               m_mode = 0;
  logic [31:0]      m_timer = '0;
  int               m_qc = 0;
  logic [ENT_W-1:0] mq[$];
  logic [15:0]      m_id = '0;
  bit               m_done = 0, m_eto = 0, m_eov = 0, m_rrwr = 0;
  longint           m_rc = 0, m_wc = 0, m_src = 0, m_swc = 0;

  // 0 = no grant, 1 = rd, 2 = wr
  function automatic int pick_of();
    if (m_mode != 1) return 0;
    if (rd_valid && wr_valid) return m_rrwr ? 2 : 1;
    if (rd_valid) return 1;
    if (wr_valid) return 2;
    return 0;
  endfunction

  function automatic longint sat32(input longint v);
    return (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v;
  endfunction

  task automatic model_step();
    int p;
    int sz0;
    bit nd;
    if (rst) begin
      m_mode = 0; m_timer = '0; m_qc = 0; mq.delete(); m_id = '0; m_done = 0;
      m_eto = 0; m_eov = 0; m_rrwr = 0; m_rc = 0; m_wc = 0; m_src = 0; m_swc = 0;
      return;
    end
    p   = pick_of();
    sz0 = mq.size();
    nd  = 0;
    if (p != 0 && trk_addr_ready) begin
      m_rrwr = !m_rrwr;
      if (p == 1) m_rc = sat32(m_rc + 1);
      else        m_wc = sat32(m_wc + 1);
    end
    if (hot_pop && sz0 != 0) void'(mq.pop_front());
    case (m_mode)
      0: if (cfg_enable) m_mode = 1;
      1: begin
        if (!cfg_enable) begin
          m_mode = 0; m_timer = '0;
        end else if ((cfg_epoch_len != 0 && m_timer == cfg_epoch_len - 32'd1) || cfg_force) begin
          if (sz0 != 0) m_eov = 1;
          mq.delete();
          m_src = m_rc; m_swc = m_wc; m_rc = 0; m_wc = 0;
          m_mode = 2; m_qc = 0; m_timer = '0;
        end else begin
          m_timer = m_timer + 32'd1;
        end
      end
      default: begin
        if (trk_mig_en && sz0 < BUF_DEPTH) mq.push_back(trk_mig_data);
        m_qc++;
        if (trk_query_ready || m_qc == QT) begin
          if (!trk_query_ready) m_eto = 1;
          nd = 1; m_id = m_id + 16'd1; m_qc = 0;
          m_mode = cfg_enable ? 1 : 0;
        end
      end
    endcase
    m_done = nd;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic compare();
    int p;
    logic [63:0] e_src, e_swc;
    p = pick_of();
`ifdef CHMU_EPOCH_STATS_EN
    e_src = 64'(m_src); e_swc = 64'(m_swc);
`else
    e_src = 64'd0; e_swc = 64'd0;
`endif
    chk("trk_addr_valid", 64'(trk_addr_valid), 64'(p != 0));
    if (p != 0) chk("trk_addr", 64'(trk_addr), (p == 2) ? 64'(wr_addr) : 64'(rd_addr));
    chk("rd_ready", 64'(rd_ready), 64'(p == 1 && trk_addr_ready));
    chk("wr_ready", 64'(wr_ready), 64'(p == 2 && trk_addr_ready));
    chk("trk_query_en", 64'(trk_query_en), 64'(m_mode == 2));
    chk("trk_mig_ready", 64'(trk_mig_ready), 64'(m_mode == 2 && mq.size() < BUF_DEPTH));
    chk("hot_valid", 64'(hot_valid), 64'(mq.size() != 0));
    chk("hot_data", 64'(hot_data), (mq.size() != 0) ? 64'(mq[0]) : 64'd0);
    chk("hot_count", 64'(hot_count), 64'(mq.size()));
    chk("epoch_done", 64'(epoch_done), 64'(m_done));
    chk("epoch_id", 64'(epoch_id), 64'(m_id));
    chk("err_timeout", 64'(err_timeout), 64'(m_eto));
    chk("err_overrun", 64'(err_overrun), 64'(m_eov));
    chk("stat_rd_cnt", 64'(stat_rd_cnt), e_src);
    chk("stat_wr_cnt", 64'(stat_wr_cnt), e_swc);
  endtask

  initial forever begin
    @(negedge clk);
    #2;
    if (chk_on) compare();
  end

  task automatic clr_inputs();
    cfg_enable = 0; cfg_force = 0; rd_valid = 0; wr_valid = 0;
    rd_addr = '0; wr_addr = '0; trk_addr_ready = 0; trk_query_ready = 0;
    trk_mig_en = 0; trk_mig_data = '0; hot_pop = 0;
  endtask

  task automatic do_reset(input logic [31:0] len);
    @(negedge clk);
    clr_inputs();
    rst = 1;
    cfg_epoch_len = len;
    @(negedge clk);
    rst = 0;
  endtask

  int cnt, pulses, qn, i, g;
  bit seen;

  initial begin
    clr_inputs();
    rst = 1;
    cfg_epoch_len = '0;
    @(negedge clk);
    @(negedge clk);
    chk_on = 1;
    #3;
    chk("reset_epoch_id", 64'(epoch_id), 64'd0);
    chk("reset_hot_count", 64'(hot_count), 64'd0);
    chk("reset_query_en", 64'(trk_query_en), 64'd0);

    // Arbiter alternation with both requesters valid, then stall.
    do_reset(0);
    cfg_enable = 1;
    @(negedge clk);
    rd_valid = 1; wr_valid = 1; trk_addr_ready = 1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      rd_addr = ADDR_SIZE'($urandom()); wr_addr = ADDR_SIZE'($urandom());
      #3;
      g = rd_ready ? 0 : (wr_ready ? 1 : 2);
      chk("arb_rr_seq", 64'(g), 64'(k % 2));
    end
    @(negedge clk);
    trk_addr_ready = 0;
    #3;
    chk("arb_stall_rd", 64'(rd_ready), 64'd0);
    chk("arb_stall_wr", 64'(wr_ready), 64'd0);

    // Timed epoch with a three-entry dump.
    do_reset(10);
    cfg_enable = 1;
    cnt = 0; seen = 0;
    while (!seen && cnt < 40) begin
      @(negedge clk);
      cnt++;
      #3;
      if (trk_query_en) seen = 1;
    end
    chk("epoch_start_latency", 64'(cnt - 1), 64'd10);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      trk_mig_en = 1; trk_mig_data = ENT_W'({$urandom(), $urandom()});
    end
    @(negedge clk);
    trk_mig_en = 0; trk_query_ready = 1;
    @(negedge clk);
    trk_query_ready = 0;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #3;
      if (k == 0) begin
        chk("epoch_id_after", 64'(epoch_id), 64'd1);
        chk("epoch_hot_count", 64'(hot_count), 64'd3);
      end
      pulses += int'(epoch_done);
    end
    chk("epoch_done_pulses", 64'(pulses), 64'd1);

    // FIFO full backpressure, then pops let the remaining entries in.
    do_reset(0);
    cfg_enable = 1;
    @(negedge clk);
    cfg_force = 1;
    @(negedge clk);
    cfg_force = 0;
    i = 0;
    for (int c = 0; c < 12 && i < 6; c++) begin
      if (c > 0) @(negedge clk);
      trk_mig_en = 1; trk_mig_data = ENT_W'({$urandom(), $urandom()});
      hot_pop = (c == 5 || c == 6);
      #3;
      if (c == 4) begin
        chk("full_mig_ready", 64'(trk_mig_ready), 64'd0);
        chk("full_count", 64'(hot_count), 64'd4);
      end
      if (trk_mig_ready) i++;
    end
    @(negedge clk);
    trk_mig_en = 0; hot_pop = 0;
    #3;
    chk("full_final_count", 64'(hot_count), 64'd4);
    trk_query_ready = 1;
    @(negedge clk);
    trk_query_ready = 0;

    // QUERY timeout with the tracker never answering.
    do_reset(0);
    cfg_enable = 1;
    @(negedge clk);
    cfg_force = 1;
    @(negedge clk);
    cfg_force = 0;
    qn = 0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      #3;
      if (trk_query_en) qn++;
      else if (qn > 0) break;
    end
    chk("timeout_cycles", 64'(qn), 64'd16);
    chk("timeout_err", 64'(err_timeout), 64'd1);
    chk("timeout_epoch_id", 64'(epoch_id), 64'd1);
    chk("timeout_done", 64'(epoch_done), 64'd1);
    rd_valid = 1;
    #1;
    chk("timeout_back_run", 64'(trk_addr_valid), 64'd1);
    @(negedge clk);
    rd_valid = 0;

    // Forced single epoch, overrun on flush, disable during QUERY.
    do_reset(0);
    cfg_enable = 1;
    @(negedge clk);
    cfg_force = 1;
    @(negedge clk);
    cfg_force = 0; trk_mig_en = 1; trk_mig_data = ENT_W'($urandom());
    @(negedge clk);
    trk_mig_data = ENT_W'($urandom());
    @(negedge clk);
    trk_mig_en = 0; trk_query_ready = 1;
    @(negedge clk);
    trk_query_ready = 0;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      #3;
      pulses += int'(epoch_done);
    end
    chk("force_single_query", 64'(pulses), 64'd1);
    @(negedge clk);
    cfg_force = 1;
    @(negedge clk);
    cfg_force = 0;
    #3;
    chk("overrun_flag", 64'(err_overrun), 64'd1);
    chk("overrun_flush_count", 64'(hot_count), 64'd0);
    cfg_enable = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #3;
      chk("disable_query_held", 64'(trk_query_en), 64'd1);
    end
    @(negedge clk);
    trk_query_ready = 1;
    @(negedge clk);
    trk_query_ready = 0; rd_valid = 1;
    #3;
    chk("disable_query_en_drop", 64'(trk_query_en), 64'd0);
    chk("disable_idle_nogrant", 64'(trk_addr_valid), 64'd0);
    @(negedge clk);
    #3;
    chk("disable_stays_idle", 64'(trk_addr_valid), 64'd0);
    rd_valid = 0;

    // Per-epoch transfer statistics: 5 reads, 3 writes.
    do_reset(0);
    cfg_enable = 1;
    @(negedge clk);
    trk_addr_ready = 1;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      rd_valid = (c < 5); wr_valid = (c >= 5);
      rd_addr = ADDR_SIZE'($urandom()); wr_addr = ADDR_SIZE'($urandom());
    end
    @(negedge clk);
    rd_valid = 0; wr_valid = 0; cfg_force = 1;
    @(negedge clk);
    cfg_force = 0;
    #3;
`ifdef CHMU_EPOCH_STATS_EN
    chk("stats_rd", 64'(stat_rd_cnt), 64'd5);
    chk("stats_wr", 64'(stat_wr_cnt), 64'd3);
`else
    chk("stats_rd_off", 64'(stat_rd_cnt), 64'd0);
    chk("stats_wr_off", 64'(stat_wr_cnt), 64'd0);
`endif

    // Randomized traffic; epoch length changes only while in reset.
    do_reset(20);
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(499) == 0) begin
        rst = 1;
        cfg_epoch_len = ($urandom_range(3) == 0) ? 32'd0 : 32'($urandom_range(40, 4));
      end else begin
        rst = 0;
      end
      cfg_enable      = ($urandom_range(99) < 98);
      cfg_force       = ($urandom_range(29) == 0);
      rd_valid        = 1'($urandom_range(1));
      wr_valid        = 1'($urandom_range(1));
      rd_addr         = ADDR_SIZE'($urandom());
      wr_addr         = ADDR_SIZE'($urandom());
      trk_addr_ready  = ($urandom_range(3) != 0);
      trk_query_ready = ($urandom_range(9) == 0);
      trk_mig_en      = ($urandom_range(3) != 0);
      trk_mig_data    = ENT_W'({$urandom(), $urandom()});
      hot_pop         = ($urandom_range(2) == 0);
    end
    @(negedge clk);
    clr_inputs();
    rst = 0;
    @(negedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
